// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and writeback.
//
// Accepts one load or store per transaction from execute. The stage then
// drives a request/grant/response handshake with the data memory, holding
// stall_out high until the transaction finishes. Loads return aligned data
// that is sign- or zero-extended to 32 bits.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   req_*                 operation from execute (valid, dir, addr, data, size, rd)
//   flush                 kill the current or incoming operation
//   stall_out             stage busy, so upstream must hold (combinational)
//   dmem_req/we/addr/     bus request side, held stable until dmem_gnt
//   wdat/be
//   dmem_gnt/rvalid/rdat  bus grant and read response
//   wb_valid/rd_ind/dat   load result to writeback (one-cycle pulse)
//   misalign, bus_err     one-cycle fault pulses
//
// All outputs are registered except stall_out.
module mem_access #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdat,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd_ind,
    input  logic        flush,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdat,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdat,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_ind,
    output logic [31:0] wb_dat,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;

    // Last timer value before the transaction is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        kill_q, kill_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;

    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdat_q, dmem_wdat_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        accept;
    logic        is_mis;
    logic [3:0]  st_be;
    logic [31:0] st_wdat;
    logic        kill_eff;
    logic        timeout;

    // Select the load lane and extend it. Reserved size 11 is handled as a word.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = {{24{b[7] & ~uns}}, b};
            2'b01:   extract = {{16{h[15] & ~uns}}, h};
            default: extract = w;
        endcase
    endfunction

    // Accept only when the request has exactly one direction (read or write).
    assign accept = req_valid & (req_read ^ req_write) & ~flush;
    assign is_mis = ((req_size == 2'b01) & req_addr[0]) |
                    (req_size[1] & (req_addr[1:0] != 2'b00));

    // Store lane placement, computed from the incoming request.
    always_comb begin
        st_be   = 4'b1111;
        st_wdat = req_wdat;
        case (req_size)
            2'b00: begin
                st_be   = 4'b0001 << req_addr[1:0];
                st_wdat = {4{req_wdat[7:0]}};
            end
            2'b01: begin
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdat = {2{req_wdat[15:0]}};
            end
            default: ;
        endcase
    end

    // A flush seen together with the response also suppresses writeback.
    assign kill_eff = kill_q | flush;
    assign timeout  = (timer_q >= TO_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        kill_d      = kill_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rd_d        = rd_q;
        dmem_req_d  = 1'b0;
        dmem_we_d   = dmem_we_q;
        dmem_addr_d = dmem_addr_q;
        dmem_wdat_d = dmem_wdat_q;
        dmem_be_d   = dmem_be_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_dat_d    = wb_dat_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mis) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        timer_d     = 8'd0;
                        kill_d      = 1'b0;
                        off_d       = req_addr[1:0];
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        rd_d        = req_rd_ind;
                        dmem_req_d  = 1'b1;
                        dmem_we_d   = req_write;
                        dmem_addr_d = {req_addr[31:2], 2'b00};
                        dmem_be_d   = req_write ? st_be : 4'b0000;
                        dmem_wdat_d = req_write ? st_wdat : 32'd0;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    // Once granted, the transaction is committed even if a flush arrives.
                    timer_d = timer_q + 8'd1;
                    if (dmem_we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = flush;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    dmem_req_d = 1'b1;
                    timer_d    = timer_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                    if (!kill_eff) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_dat_d   = extract(dmem_rdat, off_q, size_q, uns_q);
                    end
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    kill_d    = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    // A flush in WAIT is recorded; the response must still drain.
                    kill_d  = kill_eff;
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            kill_q      <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            rd_q        <= 5'd0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= 32'd0;
            dmem_wdat_q <= 32'd0;
            dmem_be_q   <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_dat_q    <= 32'd0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            kill_q      <= kill_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rd_q        <= rd_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_wdat_q <= dmem_wdat_d;
            dmem_be_q   <= dmem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_dat_q    <= wb_dat_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall_out = (state_q != S_IDLE);
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign dmem_addr = dmem_addr_q;
    assign dmem_wdat = dmem_wdat_q;
    assign dmem_be   = dmem_be_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd_ind = wb_rd_q;
    assign wb_dat    = wb_dat_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access. Expected writeback, misalign and bus_err
// events are queued when an op is driven. A negedge monitor pops and checks
// them whenever the DUT pulses one of those outputs.
module tb_mem_access;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdat = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_rd_ind = '0;
    logic        flush = 1'b0;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdat;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdat = '0;
    logic        wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd_ind;
    logic [31:0] wb_dat;

    mem_access #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdat(req_wdat), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd_ind(req_rd_ind), .flush(flush),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdat(dmem_wdat), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdat(dmem_rdat),
        .wb_valid(wb_valid), .wb_rd_ind(wb_rd_ind), .wb_dat(wb_dat),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 = writeback, 1 = misalign, 2 = bus_err.
    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [4:0] rd, input logic [31:0] dat);
        exp_t e;
        e.kind = kind;
        e.rd   = rd;
        e.dat  = dat;
        sb.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (wb_valid || misalign || bus_err)) begin
            int   k;
            exp_t e;
            k = wb_valid ? 0 : (misalign ? 1 : 2);
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                if (k == 0) begin
                    chk("wb_dat", wb_dat, e.dat);
                    chk("wb_rd_ind", 32'(wb_rd_ind), 32'(e.rd));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge. Returns at accept-edge + 1.
    task automatic drive(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit u, input logic [4:0] r);
        req_valid    = 1'b1;
        req_read     = rd;
        req_write    = ~rd;
        req_addr     = a;
        req_wdat     = wd;
        req_size     = sz;
        req_unsigned = u;
        req_rd_ind   = r;
        step();
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    // Hold off the grant for dly cycles, checking that the request stays stable.
    task automatic grant(input int dly, input logic [31:0] ea, input logic [3:0] ebe,
                         input logic [31:0] ewd, input bit ewe);
        for (int i = 0; i <= dly; i++) begin
            chk("dmem_req_held", 32'(dmem_req), 32'd1);
            chk("dmem_addr", dmem_addr, ea);
            chk("dmem_be", 32'(dmem_be), 32'(ebe));
            chk("dmem_wdat", dmem_wdat, ewd);
            chk("dmem_we", 32'(dmem_we), 32'(ewe));
            chk("stall_req", 32'(stall_out), 32'd1);
            if (i == dly) dmem_gnt = 1'b1;
            step();
        end
        dmem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdat);
        chk("dmem_req_wait", 32'(dmem_req), 32'd0);
        chk("stall_wait", 32'(stall_out), 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdat   = rdat;
        step();
        dmem_rvalid = 1'b0;
        chk("stall_done", 32'(stall_out), 32'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input bit u,
                        input logic [4:0] r, input int dly, input logic [31:0] rdat,
                        input logic [31:0] exp);
        push(0, r, exp);
        drive(1'b1, a, 32'd0, sz, u, r);
        grant(dly, {a[31:2], 2'b00}, 4'b0000, 32'd0, 1'b0);
        respond(rdat);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input int dly, input logic [3:0] ebe, input logic [31:0] ewd);
        drive(1'b0, a, wd, sz, 1'b0, 5'd0);
        grant(dly, {a[31:2], 2'b00}, ebe, ewd, 1'b1);
        chk("stall_st_done", 32'(stall_out), 32'd0);
        chk("dmem_req_st_done", 32'(dmem_req), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_out), 32'd0);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_be"}, 32'(dmem_be), 32'd0);
        chk({tag, "_wdat"}, dmem_wdat, 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbd"}, wb_dat, 32'd0);
        chk({tag, "_mis"}, 32'(misalign), 32'd0);
        chk({tag, "_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        repeat (2) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Basic loads: word, signed/unsigned byte and half, other lanes
        load(32'h0000_1000, 2'b10, 1'b0, 5'd5, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load(32'h0000_2003, 2'b00, 1'b0, 5'd6, 0, 32'h8000_0000, 32'hFFFF_FF80);
        load(32'h0000_2003, 2'b00, 1'b1, 5'd7, 1, 32'h8000_0000, 32'h0000_0080);
        load(32'h0000_2002, 2'b01, 1'b0, 5'd8, 0, 32'h8001_0000, 32'hFFFF_8001);
        load(32'h0000_2000, 2'b01, 1'b1, 5'd9, 2, 32'h1234_F00D, 32'h0000_F00D);
        load(32'h0000_3001, 2'b00, 1'b0, 5'd10, 0, 32'h0000_7F00, 32'h0000_007F);

        // Stores: half with a grant held off, byte, word
        store(32'h0000_0102, 32'h0000_ABCD, 2'b01, 3, 4'b1100, 32'hABCD_ABCD);
        store(32'h0000_0003, 32'h0000_005A, 2'b00, 0, 4'b1000, 32'h5A5A_5A5A);
        store(32'h0000_0200, 32'h1122_3344, 2'b10, 1, 4'b1111, 32'h1122_3344);

        // Misaligned ops
        push(1, 5'd0, 32'd0);
        drive(1'b1, 32'h0000_0101, 32'd0, 2'b10, 1'b0, 5'd1);
        chk("mis_stall", 32'(stall_out), 32'd0);
        chk("mis_req", 32'(dmem_req), 32'd0);
        step();
        chk("mis_req_after", 32'(dmem_req), 32'd0);
        push(1, 5'd0, 32'd0);
        drive(1'b1, 32'h0000_0103, 32'd0, 2'b01, 1'b0, 5'd1);
        chk("mis2_stall", 32'(stall_out), 32'd0);

        // Read and write both high: the op is ignored
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        step();
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        chk("rw_both_stall", 32'(stall_out), 32'd0);

        // Flush during WAIT, then the response drains without writeback
        drive(1'b1, 32'h0000_0400, 32'd0, 2'b10, 1'b0, 5'd3);
        grant(0, 32'h0000_0400, 4'b0000, 32'd0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wait_stall", 32'(stall_out), 32'd1);
        respond(32'h1111_1111);

        // Flush in the same cycle as a load grant
        drive(1'b1, 32'h0000_0500, 32'd0, 2'b10, 1'b0, 5'd4);
        flush = 1'b1; dmem_gnt = 1'b1;
        step();
        flush = 1'b0; dmem_gnt = 1'b0;
        respond(32'h2222_2222);

        // Flush in REQ before the grant
        drive(1'b1, 32'h0000_0600, 32'd0, 2'b10, 1'b0, 5'd4);
        chk("flush_req_pre", 32'(dmem_req), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_req_drop", 32'(dmem_req), 32'd0);
        chk("flush_req_idle", 32'(stall_out), 32'd0);

        // Timeout: grant never arrives
        push(2, 5'd0, 32'd0);
        drive(1'b1, 32'h0000_0700, 32'd0, 2'b10, 1'b0, 5'd2);
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_req_high", 32'(dmem_req), 32'd1);
            step();
        end
        chk("to_req_low", 32'(dmem_req), 32'd0);
        chk("to_idle", 32'(stall_out), 32'd0);
        load(32'h0000_0800, 2'b10, 1'b0, 5'd11, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Reset in the middle of REQ
        drive(1'b1, 32'h0000_0900, 32'd0, 2'b10, 1'b0, 5'd12);
        chk("rst_mid_pre", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst_n = 1'b1;
        step();
        load(32'h0000_0A00, 2'b00, 1'b0, 5'd13, 0, 32'h0000_00FF, 32'hFFFF_FFFF);

        repeat (3) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something wedges the run
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
